// File: rtl/seq_addsub_pkg.sv
// Shared types and constants for the chunked sequential adder/subtractor.
// Optional saturation is selected by the SEQ_ADDSUB_SAT_EN macro in seq_addsub.sv.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_if.sv
// Request/response bundle for seq_addsub: valid/ready operand input and result output.
interface seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero
  );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out, reused every CALC cycle.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/seq_addsub.sv
// Sequential add/subtract processing CHUNK bits per clock through one shared adder slice.
// Define SEQ_ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = $clog2(NCH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, raw_q, raw_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             op_q, op_d, cy_q, cy_d, sa_q, sa_d, sb_q, sb_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ovf_w;
  logic [WIDTH-1:0] final_w;

  // Operands shift right each cycle, so the slice always sees the low chunk.
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (cy_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  assign ovf_w = (sa_q == sb_q) && (raw_q[WIDTH-1] != sa_q);

`ifdef SEQ_ADDSUB_SAT_EN
  assign final_w = !ovf_w ? raw_q :
                   raw_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign final_w = raw_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    k_d      = k_q;
    op_d     = op_q;
    cy_d     = cy_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
          op_d    = bus.op;
          cy_d    = bus.op;
          sa_d    = bus.a[WIDTH-1];
          sb_d    = b_d[WIDTH-1];
          raw_d   = '0;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (k_q != KW'(NCH)) begin
          a_d   = a_q >> CHUNK;
          b_d   = b_q >> CHUNK;
          raw_d = (raw_q >> CHUNK) | (WIDTH'(ch_sum) << (WIDTH - CHUNK));
          cy_d  = ch_cout;
          k_d   = k_q + KW'(1);
        end else begin
          // All chunks done: this extra cycle registers the final result and flags.
          result_d = final_w;
          carry_d  = cy_q ^ op_q;
          ovf_d    = ovf_w;
          zero_d   = (final_w == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      k_q      <= '0;
      op_q     <= 1'b0;
      cy_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      k_q      <= k_d;
      op_q     <= op_d;
      cy_q     <= cy_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub (WIDTH=8, CHUNK=4): directed table, random ops, stall and reset cases.
// Honours SEQ_ADDSUB_SAT_EN in its reference model.
module tb_seq_addsub;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    res_t       exp;
    int         stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(8)) bus ();

  seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
    res_t r;
    int   s, u;
    if (op) begin
      s       = int'($signed(a)) - int'($signed(b));
      u       = int'(a) - int'(b);
      r.carry = (int'(a) < int'(b));
    end else begin
      s       = int'($signed(a)) + int'($signed(b));
      u       = int'(a) + int'(b);
      r.carry = (u > 255);
    end
    r.ovf    = (s > 127) || (s < -128);
    r.result = 8'(u);
`ifdef SEQ_ADDSUB_SAT_EN
    if (r.ovf) r.result = (s > 127) ? 8'h7F : 8'h80;
`endif
    r.zero = (r.result == 8'h00);
    return r;
  endfunction

  task automatic check_outs(input string tag, input res_t e);
    check({tag, "_result"}, int'(bus.result), int'(e.result));
    check({tag, "_carry"},  int'(bus.carry),  int'(e.carry));
    check({tag, "_ovf"},    int'(bus.ovf),    int'(e.ovf));
    check({tag, "_zero"},   int'(bus.zero),   int'(e.zero));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_wait"}, int'(bus.in_ready), 1);
  endtask

  // Issue one op, garble the inputs while busy, check latency, hold and release.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input res_t e, input int stall);
    int cyc;
    wait_idle(tag);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a  = 8'($urandom);
    bus.b  = 8'($urandom);
    bus.op = 1'($urandom);
    check({tag, "_busy_in_ready"}, int'(bus.in_ready), 0);
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cyc = i;
        break;
      end
    end
    check({tag, "_latency"}, cyc, 3);
    check_outs(tag, e);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, int'(bus.out_valid), 1);
      check({tag, "_stall_in_ready"}, int'(bus.in_ready), 0);
      check({tag, "_stall_result"}, int'(bus.result), int'(e.result));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, int'(bus.out_valid), 0);
    check({tag, "_post_in_ready"}, int'(bus.in_ready), 1);
    $display("txn %s: op=%0d a=0x%02h b=0x%02h -> result=0x%02h carry=%0d ovf=%0d zero=%0d",
             tag, op, a, b, e.result, e.carry, e.ovf, e.zero);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_in_ready"},  int'(bus.in_ready),  1);
    check_outs(tag, '0);
  endtask

  vec_t vecs[8];

  initial begin
    res_t e;
    int   seen;

    vecs[0] = '{8'h05, 8'h03, 1'b1, '{8'h02, 1'b0, 1'b0, 1'b0}, 0};
    vecs[1] = '{8'h03, 8'h05, 1'b1, '{8'hFE, 1'b1, 1'b0, 1'b0}, 1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1}, 0};
`ifdef SEQ_ADDSUB_SAT_EN
    vecs[3] = '{8'h7F, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b0}, 0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, '{8'h80, 1'b0, 1'b1, 1'b0}, 0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, '{8'h80, 1'b1, 1'b1, 1'b0}, 0};
`else
    vecs[3] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}, 0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, '{8'h7F, 1'b0, 1'b1, 1'b0}, 0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1}, 0};
`endif
    vecs[6] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}, 0};
    vecs[7] = '{8'h3C, 8'h5A, 1'b0, '{8'h96, 1'b0, 1'b1, 1'b0}, 5};
`ifdef SEQ_ADDSUB_SAT_EN
    vecs[7].exp.result = 8'h7F;
`endif

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;

    // Power-on reset, checked before the first clock edge.
    #1 rst = 1'b1;
    #2 reset_checks("por");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].stall);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rop, model(ra, rb, rop), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of CALC: cleared immediately, no result afterwards.
    wait_idle("rst_calc");
    bus.a = 8'h12; bus.b = 8'h34; bus.op = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 reset_checks("rst_calc");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rst_calc_no_result", seen, 0);
    $display("txn rst_calc: reset during CALC, operation discarded");

    // Reset while a nonzero result is waiting in DONE.
    wait_idle("rst_done");
    bus.a = 8'h21; bus.b = 8'h13; bus.op = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_done_valid_before", int'(bus.out_valid), 1);
    check("rst_done_result_before", int'(bus.result), 8'h34);
    #1 rst = 1'b1;
    #1 reset_checks("rst_done");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rst_done_no_result", seen, 0);
    $display("txn rst_done: reset during DONE, result dropped");

    e = model(8'hA5, 8'h5A, 1'b1);
    run_op("recover", 8'hA5, 8'h5A, 1'b1, e, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
